// File: rtl/viu_route_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : viu_route_arbiter
//  Description : Controller for the VIU routing-capability table. Accepts host
//                capability writes and round-robin arbitrates route-lookup
//                requests from N_REQ user-logic ports, one lookup at a time.
//                Each lookup returns the stored 14-bit capability plus an
//                allow/deny verdict for the requesting user-logic port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_REQ    number of user-logic requesters (1..16), index = ul_id
//    N_DESTS  routing-table entries (1..4), indexed by port_id[1:0]
//  Ports
//    aclk, aresetn          clock, synchronous active-low reset
//    cfg_valid/ready/data   host capability write
//                           data: [9:6] sender_ul_id, [1:0] port_id
//    req_valid/ready/port   per-requester lookup, req_ready one-hot grant
//    resp_valid/ready       lookup result handshake
//    resp_id/allow/route    requester index, verdict, stored capability
//    stat_allow/stat_deny   handshaken-response counters
//  Build option
//    VIU_ROUTE_STATS_EN     when defined, builds saturating 32-bit counters
//                           behind stat_allow/stat_deny; otherwise both are 0
// ============================================================================
module viu_route_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_DESTS = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [13:0]          cfg_data,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_port,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [3:0]           resp_id,
    output logic                 resp_allow,
    output logic [13:0]          resp_route,
    output logic [31:0]          stat_allow,
    output logic [31:0]          stat_deny
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WRITE  = 2'd1;
    localparam logic [1:0] c_ST_LOOKUP = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0]  r_state;
    logic [3:0]  r_rr_ptr;
    logic [3:0]  r_id;
    logic [1:0]  r_port;
    logic [13:0] r_cfg_data;

    logic        r_resp_valid;
    logic [3:0]  r_resp_id;
    logic        r_resp_allow;
    logic [13:0] r_resp_route;

    // Table is always viewed as 4 entries; entries beyond N_DESTS read as
    // invalid so the lookup index never leaves the array.
    logic        w_vld [4];
    logic [13:0] w_cap [4];

    logic [15:0] w_req_ext;
    logic [4:0]  w_idx;
    logic        w_found;
    logic [3:0]  w_gnt_id;
    logic [1:0]  w_gnt_port;
    logic        w_idle;
    logic        w_grant;
    logic        w_resp_hs;
    logic        w_in_range;
    logic        w_hit_vld;

    assign w_req_ext = 16'(req_valid);
    assign w_idle    = aresetn && (r_state == c_ST_IDLE);
    assign w_grant   = w_idle && !cfg_valid && w_found;
    assign w_resp_hs = r_resp_valid && resp_ready;

    assign cfg_ready = w_idle && cfg_valid;

    // Round-robin search: first valid requester at or after r_rr_ptr.
    always_comb begin
        w_idx      = '0;
        w_found    = 1'b0;
        w_gnt_id   = '0;
        w_gnt_port = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = 5'(r_rr_ptr) + 5'(k);
            if (w_idx >= 5'(N_REQ)) begin
                w_idx = w_idx - 5'(N_REQ);
            end
            if (!w_found && w_req_ext[w_idx[3:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[3:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_id == 4'(i)) begin
                w_gnt_port = req_port[2*i +: 2];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_grant && (w_gnt_id == 4'(i));
        end
    end

    genvar e;
    generate
        for (e = 0; e < 4; e++) begin : g_entry
            if (e < N_DESTS) begin : g_real
                logic        r_vld;
                logic [13:0] r_cap;
                always_ff @(posedge aclk) begin
                    if (!aresetn) begin
                        r_vld <= 1'b0;
                        r_cap <= '0;
                    end else if ((r_state == c_ST_WRITE) &&
                                 (r_cfg_data[1:0] == 2'(e))) begin
                        r_vld <= 1'b1;
                        r_cap <= r_cfg_data;
                    end
                end
                assign w_vld[e] = r_vld;
                assign w_cap[e] = r_cap;
            end else begin : g_none
                // Writes to this port_id are handshaken and then dropped.
                assign w_vld[e] = 1'b0;
                assign w_cap[e] = '0;
            end
        end
    endgenerate

    assign w_in_range = (3'(r_port) < 3'(N_DESTS));
    assign w_hit_vld  = w_vld[r_port] && w_in_range;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= c_ST_IDLE;
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_port       <= '0;
            r_cfg_data   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_allow <= 1'b0;
            r_resp_route <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (cfg_valid) begin
                        r_cfg_data <= cfg_data;
                        r_state    <= c_ST_WRITE;
                    end else if (w_found) begin
                        r_id    <= w_gnt_id;
                        r_port  <= w_gnt_port;
                        r_state <= c_ST_LOOKUP;
                    end
                end
                c_ST_WRITE: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_LOOKUP: begin
                    r_resp_valid <= 1'b1;
                    r_resp_id    <= r_id;
                    r_resp_route <= w_hit_vld ? w_cap[r_port] : 14'd0;
                    r_resp_allow <= w_hit_vld && (w_cap[r_port][9:6] == r_id);
                    r_rr_ptr     <= (r_id == 4'(N_REQ - 1)) ? 4'd0 : r_id + 4'd1;
                    r_state      <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (w_resp_hs) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_allow = r_resp_allow;
    assign resp_route = r_resp_route;

`ifdef VIU_ROUTE_STATS_EN
    logic [31:0] r_stat_allow;
    logic [31:0] r_stat_deny;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_stat_allow <= '0;
            r_stat_deny  <= '0;
        end else if (w_resp_hs) begin
            if (r_resp_allow) begin
                if (r_stat_allow != 32'hFFFF_FFFF) begin
                    r_stat_allow <= r_stat_allow + 32'd1;
                end
            end else begin
                if (r_stat_deny != 32'hFFFF_FFFF) begin
                    r_stat_deny <= r_stat_deny + 32'd1;
                end
            end
        end
    end

    assign stat_allow = r_stat_allow;
    assign stat_deny  = r_stat_deny;
`else
    assign stat_allow = '0;
    assign stat_deny  = '0;
`endif

endmodule
`default_nettype wire
